// File: rtl/alu_exec_unit.sv
// alu_exec_unit: 16-bit ALU behind a valid/ready request channel with a response FIFO.
module alu_exec_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_overflow,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [15:0]      txn_count,
    output logic [15:0]      err_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = TAG_W + 4 + WIDTH;

    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    entry, head, last;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] res;
    logic             carry, ovf, err, push, pop;

    assign sum  = {1'b0, req_a} + {1'b0, req_b};
    assign diff = {1'b0, req_a} - {1'b0, req_b};

    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        err   = 1'b0;
        case (req_op)
            4'd0: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (req_a[WIDTH-1] == req_b[WIDTH-1]) && (sum[WIDTH-1] != req_a[WIDTH-1]);
            end
            4'd1: begin
                res   = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = (req_a[WIDTH-1] != req_b[WIDTH-1]) && (diff[WIDTH-1] != req_a[WIDTH-1]);
            end
            4'd2: res = req_a & req_b;
            4'd3: res = req_a | req_b;
            4'd4: res = req_a ^ req_b;
            4'd5: {carry, res} = {req_a, 1'b0};
            4'd6: {res, carry} = {1'b0, req_a};
            default: err = 1'b1;
        endcase
    end

    assign entry     = {req_tag, err, ~|res, ovf, carry, res};
    assign head      = mem[rd_ptr];
    assign req_ready = count < CW'(DEPTH);
    assign rsp_valid = count != '0;
    assign push      = req_valid & req_ready;
    assign pop       = rsp_valid & rsp_ready;

    // Outputs show the head while non-empty and otherwise keep the last delivered entry.
    assign {rsp_tag, rsp_err, rsp_zero, rsp_overflow, rsp_carry, rsp_result} = rsp_valid ? head : last;

    always_ff @(posedge clk)
        if (push)
            mem[wr_ptr] <= entry;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last      <= '0;
            txn_count <= '0;
            err_count <= '0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last      <= head;
                txn_count <= txn_count + 16'd1;
                err_count <= err_count + 16'(rsp_err);
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors with a scoreboard queue checked by a response monitor.
module tb_alu_exec_unit;
    logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, rsp_ready = 1'b0;
    logic [15:0] req_a = '0, req_b = '0;
    logic [3:0]  req_op = '0, req_tag = '0;
    logic        req_ready, rsp_valid, rsp_carry, rsp_overflow, rsp_zero, rsp_err;
    logic [15:0] rsp_result, txn_count, err_count;
    logic [3:0]  rsp_tag;
    logic [23:0] q[$];
    int          total = 0, bad = 0, cyc = 0, acc_cyc = 0, rel = 0, first = 0;

    alu_exec_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
        .rsp_err(rsp_err), .rsp_tag(rsp_tag), .txn_count(txn_count), .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // A response is taken at the edge following this negedge unless reset is asserted for it.
    always @(negedge clk) begin
        logic [23:0] got, want;
        if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            got = {rsp_tag, rsp_err, rsp_zero, rsp_overflow, rsp_carry, rsp_result};
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got %h want none", got);
            end else begin
                want = q.pop_front();
                chk("rsp", {8'h0, got}, {8'h0, want});
            end
        end
    end

    // flg = {err, zero, overflow, carry}
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] tag, input logic [15:0] res, input logic [3:0] flg);
        bit ok = 0;
        req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                q.push_back({tag, flg, res});
                acc_cyc = cyc + 1;
                ok = 1;
            end
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got req_ready=%b want 1", req_ready);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && q.size() != 0; t++) @(posedge clk);
        #1 chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_txn", txn_count, 0);
        chk("rst_err", err_count, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_tag", rsp_tag, 0);
        rsp_ready = 1'b1;
        issue(4'd0, 16'h7FFF, 16'h0001, 4'd3, 16'h8000, 4'b0010);
        chk("latency", rsp_valid, 1);
        drain();
        chk("txn_1", txn_count, 1);
        issue(4'd1, 16'h0005, 16'h0007, 4'd1, 16'hFFFE, 4'b0001);
        issue(4'd0, 16'hFFFF, 16'h0001, 4'd2, 16'h0000, 4'b0101);
        drain();
        rsp_ready = 1'b0;
        issue(4'd2, 16'h0F0F, 16'h00FF, 4'd1, 16'h000F, 4'b0000);
        issue(4'd3, 16'h0F00, 16'h00F0, 4'd2, 16'h0FF0, 4'b0000);
        issue(4'd4, 16'hFFFF, 16'h0F0F, 4'd3, 16'hF0F0, 4'b0000);
        issue(4'd0, 16'h1234, 16'h1111, 4'd4, 16'h2345, 4'b0000);
        chk("full_ready", req_ready, 0);
        fork
            issue(4'd1, 16'h0010, 16'h0001, 4'd5, 16'h000F, 4'b0000);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_ready", req_ready, 0);
                    chk("head_hold", {rsp_valid, rsp_tag, rsp_result}, {1'b1, 4'd1, 16'h000F});
                end
                @(posedge clk);
                #1 rsp_ready = 1'b1;
                rel = cyc;
            end
        join
        chk("fifth_accept", acc_cyc, rel + 2);
        drain();
        chk("txn_8", txn_count, 8);
        for (int i = 0; i < 20; i++) begin
            issue(4'd2, 16'(i) * 16'h0101, 16'h00FF, 4'(i), 16'(i), (i == 0) ? 4'b0100 : 4'b0000);
            if (i == 0) first = acc_cyc;
        end
        chk("stream_span", acc_cyc - first, 19);
        drain();
        chk("txn_28", txn_count, 28);
        issue(4'd9, 16'h1234, 16'h0000, 4'd6, 16'h0000, 4'b1100);
        issue(4'd5, 16'h8001, 16'h0000, 4'd7, 16'h0002, 4'b0001);
        issue(4'd6, 16'h8001, 16'h0000, 4'd8, 16'h4000, 4'b0001);
        drain();
        chk("err_1", err_count, 1);
        chk("txn_31", txn_count, 31);
        rsp_ready = 1'b0;
        issue(4'd2, 16'hAAAA, 16'hFFFF, 4'd9, 16'hAAAA, 4'b0000);
        issue(4'd3, 16'h0001, 16'h0002, 4'd10, 16'h0003, 4'b0000);
        issue(4'd4, 16'h00FF, 16'h00FF, 4'd11, 16'h0000, 4'b0100);
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst2_valid", rsp_valid, 0);
        chk("rst2_ready", req_ready, 1);
        chk("rst2_txn", txn_count, 0);
        chk("rst2_err", err_count, 0);
        rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("no_stale_valid", rsp_valid, 0);
        chk("no_stale_txn", txn_count, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
